// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, threshold and sticky error flags.
// FWFT=0 gives a registered read port; FWFT=1 presents the head word combinationally.
module sync_fifo_param #(
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 3,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  typedef logic [ADDR_W:0] ptr_t;
  localparam ptr_t AF_L = ptr_t'(AF_LEVEL);
  localparam ptr_t AE_L = ptr_t'(AE_LEVEL);

  ptr_t              wr_ptr, rd_ptr, lvl;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              push_ok, pop_ok;

  // Wrap bit distinguishes full from empty when the low address bits match.
  assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty        = (wr_ptr == rd_ptr);
  assign almost_full  = (lvl >= AF_L);
  assign almost_empty = (lvl <= AE_L);
  assign level        = lvl;

  // Acceptance is judged against the registered flags only.
  assign push_ok = wr_en & ~full;
  assign pop_ok  = rd_en & ~empty;

  // Storage array: written on accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ptr_t'(1);
      case ({push_ok, pop_ok})
        2'b10:   lvl <= lvl + ptr_t'(1);
        2'b01:   lvl <= lvl - ptr_t'(1);
        default: lvl <= lvl;
      endcase
    end
  end

  // Sticky error flags; a fresh error in the clear cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | (wr_en & full);
      underflow <= (underflow & ~clr_err) | (rd_en & empty);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always on the output while the FIFO holds data.
      assign rd_data  = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
      assign rd_valid = ~empty;
    end else begin : g_reg
      logic [DATA_W-1:0] rd_q;
      logic              vld_q;
      // Registered read: data lands one edge after the accepted pop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q  <= '0;
          vld_q <= 1'b0;
        end else begin
          vld_q <= pop_ok;
          if (pop_ok) rd_q <= mem[rd_ptr[ADDR_W-1:0]];
        end
      end
      assign rd_data  = rd_q;
      assign rd_valid = vld_q;
    end
  endgenerate

endmodule
